pipe_hazard_sb: RTL and testbench
=================================

PIPE_HAZARD_SB -- requirements
Module: pipe_hazard_sb

Interface
REQ-001 Parameter DEPTH, default 3: number of pipeline stages after decode; stage DEPTH is the register-file write stage; range 2..8.
REQ-002 Parameter AW, default 5: register address width.
REQ-003 Parameter FWD_EN, default 1: 1 = forwarding enabled, 0 = stall-only mode.
REQ-004 Parameter CW, default 16: stall counter width; SW = clog2(DEPTH+1) is the width of the forward selects and of id_rdy.
REQ-005 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-006 Port clock, input, 1: rising-edge clock.
REQ-007 Port resetn, input, 1: asynchronous active-low reset.
REQ-008 Port id_valid, input, 1: the decode stage holds a live instruction.
REQ-009 Ports id_rs and id_rt, input, AW each: decode source register numbers.
REQ-010 Ports id_use_rs and id_use_rt, input, 1 each: the instruction actually reads that source.
REQ-011 Port id_wreg, input, 1: the decode instruction writes the register file.
REQ-012 Port id_rd, input, AW: destination register number.
REQ-013 Port id_rdy, input, SW: first stage (1..DEPTH) at which the result can be forwarded; 1 = ALU, 2 = load.
REQ-014 Port flush, input, 1: kill the decode instruction because of a redirect.
REQ-015 Port hold, input, 1: downstream freeze.
REQ-016 Ports fwda and fwdb, output, SW each: 0 = register file, k = value from stage k.
REQ-017 Port stall, output, 1: the decode stage must not advance.
REQ-018 Port wpcir, output, 1: equals ~stall; PC and IF/ID write enable.
REQ-019 Port stall_cnt, output, CW: saturating count of hazard-stall cycles.

Function
REQ-020 SHALL keep a shift register of DEPTH entries, each {v, wreg, rd, rdy}, where entry k describes stage k.
REQ-021 When hold=0, each clock edge SHALL move entry k to entry k+1 and drop entry DEPTH.
REQ-022 Entry 1 SHALL load the decode instruction when id_valid & ~stall & ~flush; otherwise entry 1 loads a bubble with v=0.
REQ-023 When hold=1, all entries SHALL be held unchanged.
REQ-024 id_rdy values of 0 or greater than DEPTH SHALL be stored as DEPTH.
REQ-025 For each used source s, a match at stage k SHALL mean: v, wreg, rd==s and s!=0; the youngest match (smallest k) governs.
REQ-026 With FWD_EN=1, a governing match with k >= rdy SHALL set fwd = k.
REQ-027 With FWD_EN=1, a governing match with k < rdy SHALL raise a hazard.
REQ-028 With FWD_EN=1 and no match, fwd SHALL be 0.
REQ-029 With FWD_EN=0, fwd SHALL always be 0, and any match at k < DEPTH SHALL raise a hazard; the register file is write-through.
REQ-030 A source whose use flag is 0, or whose number is 0, SHALL never raise a hazard and SHALL select fwd = 0.
REQ-031 hz = id_valid & ~flush & (hazard on rs | hazard on rt).
REQ-032 stall = hz | hold; stall, wpcir and fwd are combinational from the entries and the decode inputs.
REQ-033 When flush=1 together with a hazard, flush wins: hz = 0 and a bubble enters.
REQ-034 stall_cnt SHALL increment on each edge with hz & ~hold, and saturate at 2^CW-1.

Reset
REQ-035 When resetn=0, all entry v bits SHALL be 0 and stall_cnt SHALL be 0, so fwda=fwdb=0, stall=0 and wpcir=1 with hold=0 and no live hazard inputs.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight entries immediately.

Verification (DEPTH=3, FWD_EN=1)
REQ-037 ALU back-to-back: producer rd=3, rdy=1, then a consumer with rs=3 -> next cycle fwda=1, stall=0; one cycle later fwda=2.
REQ-038 Load-use: producer rd=4, rdy=2, then a consumer with rt=4 -> first cycle stall=1, wpcir=0, stall_cnt=1; next cycle fwdb=2, stall=0.
REQ-039 Same rd=5 at stages 1 and 2, both rdy=1 -> fwda=1 (youngest); a producer with rd=0 -> fwda=0.
REQ-040 Load-use hazard with flush=1 -> stall=0, entry 1 is a bubble, stall_cnt unchanged.
REQ-041 hold=1 for 3 cycles during a load-use case -> entries frozen, stall=1, stall_cnt unchanged; after hold drops, the stall resolves one cycle later.
REQ-042 resetn pulsed low with 3 live entries -> fwda=fwdb=0, stall_cnt=0; a prior consumer sees no hazard.
REQ-043 FWD_EN=0: producer rd=3, rdy=1 followed by a consumer of r3 -> 2 stall cycles, then fwda=0.

Source files
------------

// File: rtl/pipe_hazard_sb.sv
// Hazard scoreboard for an in-order pipeline.
// Tracks which register each of the DEPTH post-decode stages will write.
// From that it picks a forwarding stage for each decode source, or stalls
// decode when the value is not yet available.
`timescale 1ns/1ps
module pipe_hazard_sb #(
  parameter int DEPTH  = 3,
  parameter int AW     = 5,
  parameter int FWD_EN = 1,
  parameter int CW     = 16,
  localparam int SW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_wreg,
  input  logic [AW-1:0] id_rd,
  input  logic [SW-1:0] id_rdy,
  input  logic          flush,
  input  logic          hold,
  output logic [SW-1:0] fwda,
  output logic [SW-1:0] fwdb,
  output logic          stall,
  output logic          wpcir,
  output logic [CW-1:0] stall_cnt
);

  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  // Entry k describes pipeline stage k (1 = just past decode, DEPTH = write-back).
  logic [DEPTH:1]         e_v;
  logic [DEPTH:1]         e_wreg;
  logic [DEPTH:1][AW-1:0] e_rd;
  logic [DEPTH:1][SW-1:0] e_rdy;

  logic [SW-1:0] rdy_norm;
  logic          hz;
  logic [AW-1:0] src   [2];
  logic          use_s [2];
  logic [SW-1:0] fwd   [2];
  logic          shz   [2];
  logic          found;
  logic [SW-1:0] kf;
  logic [SW-1:0] rdyf;

  // Out-of-range ready stages mean "only available from the write-back stage".
  always_comb begin
    rdy_norm = id_rdy;
    if (id_rdy == '0 || id_rdy > DEPTH_S) rdy_norm = DEPTH_S;
  end

  // Per-source lookup: the youngest matching stage decides forward vs hazard.
  always_comb begin
    src[0]   = id_rs;
    src[1]   = id_rt;
    use_s[0] = id_use_rs;
    use_s[1] = id_use_rt;
    fwd[0]   = '0;
    fwd[1]   = '0;
    shz[0]   = 1'b0;
    shz[1]   = 1'b0;
    found    = 1'b0;
    kf       = '0;
    rdyf     = '0;
    for (int j = 0; j < 2; j++) begin
      found = 1'b0;
      kf    = '0;
      rdyf  = '0;
      // Scan oldest to youngest so the youngest match is the one left standing.
      for (int k = DEPTH; k >= 1; k--) begin
        if (e_v[k] && e_wreg[k] && e_rd[k] == src[j]) begin
          found = 1'b1;
          kf    = SW'(k);
          rdyf  = e_rdy[k];
        end
      end
      if (use_s[j] && src[j] != '0 && found) begin
        if (FWD_EN != 0) begin
          if (kf >= rdyf) fwd[j] = kf;
          else            shz[j] = 1'b1;
        end else begin
          // Stall-only: the write-through register file covers the write-back stage.
          shz[j] = (kf < DEPTH_S);
        end
      end
    end
  end

  // Hazard and stall; a redirect kills the decode instruction, so it never stalls.
  always_comb begin
    hz    = id_valid & ~flush & (shz[0] | shz[1]);
    stall = hz | hold;
    wpcir = ~stall;
    fwda  = fwd[0];
    fwdb  = fwd[1];
  end

  // Stage shift register; frozen by hold, bubble inserted on stall or flush.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      e_v    <= '0;
      e_wreg <= '0;
      e_rd   <= '0;
      e_rdy  <= '0;
    end else if (!hold) begin
      e_v[DEPTH:2]    <= e_v[DEPTH-1:1];
      e_wreg[DEPTH:2] <= e_wreg[DEPTH-1:1];
      e_rd[DEPTH:2]   <= e_rd[DEPTH-1:1];
      e_rdy[DEPTH:2]  <= e_rdy[DEPTH-1:1];
      e_v[1]          <= id_valid & ~stall & ~flush;
      e_wreg[1]       <= id_wreg;
      e_rd[1]         <= id_rd;
      e_rdy[1]        <= rdy_norm;
    end
  end

  // Saturating count of cycles lost to real hazards (hold cycles excluded).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (hz && !hold && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_sb.sv
// Bench for pipe_hazard_sb: a forwarding instance and a stall-only instance
// (narrow counter) share stimulus and are compared to a stage-list model.
`timescale 1ns/1ps
module tb_pipe_hazard_sb;
  localparam int DEPTH = 3;
  localparam int AW    = 5;
  localparam int SW    = 2;
  localparam int CW0   = 16;
  localparam int CW1   = 3;

  logic          clock = 1'b0;
  logic          resetn;
  logic          id_valid, id_use_rs, id_use_rt, id_wreg, flush, hold;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [SW-1:0] id_rdy;
  logic [SW-1:0] fwda0, fwdb0, fwda1, fwdb1;
  logic          stall0, wpcir0, stall1, wpcir1;
  logic [CW0-1:0] cnt0;
  logic [CW1-1:0] cnt1;

  always #5 clock = ~clock;

  pipe_hazard_sb #(.DEPTH(DEPTH), .AW(AW), .FWD_EN(1), .CW(CW0)) u_fwd (
    .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_rd(id_rd),
    .id_rdy(id_rdy), .flush(flush), .hold(hold), .fwda(fwda0), .fwdb(fwdb0),
    .stall(stall0), .wpcir(wpcir0), .stall_cnt(cnt0));

  pipe_hazard_sb #(.DEPTH(DEPTH), .AW(AW), .FWD_EN(0), .CW(CW1)) u_stl (
    .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_rd(id_rd),
    .id_rdy(id_rdy), .flush(flush), .hold(hold), .fwda(fwda1), .fwdb(fwdb1),
    .stall(stall1), .wpcir(wpcir1), .stall_cnt(cnt1));

  typedef struct {bit v; bit wreg; int rd; int rdy;} ent_t;

  // Model m=0: forwarding instance, m=1: stall-only instance.
  ent_t mp [2][1:DEPTH];
  int   mcnt [2];
  int   cmax [2] = '{(1 << CW0) - 1, (1 << CW1) - 1};
  int   n_pass = 0;
  int   n_total = 0;
  int   saved;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  function automatic void src_eval(input int m, input int s, input bit u,
                                   output int fwd, output bit hz);
    int k;
    k = 0; fwd = 0; hz = 1'b0;
    if (!u || s == 0) return;
    for (int i = 1; i <= DEPTH; i++)
      if (mp[m][i].v && mp[m][i].wreg && mp[m][i].rd == s) begin k = i; break; end
    if (k == 0) return;
    if (m == 0) begin
      if (k >= mp[m][k].rdy) fwd = k;
      else hz = 1'b1;
    end else begin
      hz = (k < DEPTH);
    end
  endfunction

  function automatic void model_out(input int m, output int fa, output int fb,
                                    output bit hz, output bit st);
    bit ha, hb;
    src_eval(m, int'(id_rs), id_use_rs, fa, ha);
    src_eval(m, int'(id_rt), id_use_rt, fb, hb);
    hz = id_valid && !flush && (ha || hb);
    st = hz || hold;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 1; i <= DEPTH; i++) mp[m][i] = '{1'b0, 1'b0, 0, 0};
      mcnt[m] = 0;
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cyc();
    int fa, fb; bit hz, st;
    ent_t nxt [2][1:DEPTH];
    int ncnt [2];
    @(negedge clock);
    for (int m = 0; m < 2; m++) begin
      model_out(m, fa, fb, hz, st);
      chk($sformatf("m%0d fwda", m), (m == 0) ? 32'(fwda0) : 32'(fwda1), fa);
      chk($sformatf("m%0d fwdb", m), (m == 0) ? 32'(fwdb0) : 32'(fwdb1), fb);
      chk($sformatf("m%0d stall", m), (m == 0) ? 32'(stall0) : 32'(stall1), 32'(st));
      chk($sformatf("m%0d wpcir", m), (m == 0) ? 32'(wpcir0) : 32'(wpcir1), 32'(!st));
      chk($sformatf("m%0d stall_cnt", m), (m == 0) ? 32'(cnt0) : 32'(cnt1), mcnt[m]);
      for (int i = 1; i <= DEPTH; i++) nxt[m][i] = mp[m][i];
      if (!hold) begin
        for (int i = DEPTH; i >= 2; i--) nxt[m][i] = mp[m][i-1];
        nxt[m][1].v    = id_valid && !st && !flush;
        nxt[m][1].wreg = id_wreg;
        nxt[m][1].rd   = int'(id_rd);
        nxt[m][1].rdy  = (id_rdy == 0 || int'(id_rdy) > DEPTH) ? DEPTH : int'(id_rdy);
      end
      ncnt[m] = mcnt[m];
      if (hz && !hold && mcnt[m] < cmax[m]) ncnt[m] = mcnt[m] + 1;
    end
    @(posedge clock);
    for (int m = 0; m < 2; m++) begin
      for (int i = 1; i <= DEPTH; i++) mp[m][i] = nxt[m][i];
      mcnt[m] = ncnt[m];
    end
    #1;
  endtask

  task automatic set_id(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                        input bit w, input int rd, input int rdy);
    id_valid = v; id_rs = AW'(rs); id_use_rs = urs; id_rt = AW'(rt); id_use_rt = urt;
    id_wreg = w; id_rd = AW'(rd); id_rdy = SW'(rdy);
    #1;
  endtask

  task automatic idle(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    chk("rst fwda", 32'(fwda0), 0);
    chk("rst fwdb", 32'(fwdb0), 0);
    chk("rst cnt", 32'(cnt0), 0);
    chk("rst cnt1", 32'(cnt1), 0);
    #1;
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; hold = 1'b0;
    id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_wreg = 0; id_rd = '0; id_rdy = '0;
    model_reset();
    #12;
    chk("reset fwda", 32'(fwda0), 0);
    chk("reset fwdb", 32'(fwdb0), 0);
    chk("reset stall", 32'(stall0), 0);
    chk("reset wpcir", 32'(wpcir0), 1);
    chk("reset cnt", 32'(cnt0), 0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // ALU back-to-back forwarding
    idle(4);
    set_id(1, 0, 0, 0, 0, 1, 3, 1); cyc();
    set_id(1, 3, 1, 0, 0, 0, 0, 1);
    chk("alu fwda k1", 32'(fwda0), 1);
    chk("alu stall", 32'(stall0), 0);
    cyc();
    chk("alu fwda k2", 32'(fwda0), 2);
    cyc();

    // Load-use stall from a fresh reset
    do_reset();
    idle(4);
    set_id(1, 0, 0, 0, 0, 1, 4, 2); cyc();
    set_id(1, 0, 0, 4, 1, 0, 0, 1);
    chk("ld stall", 32'(stall0), 1);
    chk("ld wpcir", 32'(wpcir0), 0);
    cyc();
    chk("ld cnt", 32'(cnt0), 1);
    chk("ld fwdb", 32'(fwdb0), 2);
    chk("ld stall after", 32'(stall0), 0);
    cyc();

    // Youngest match wins; register 0 never matches
    idle(4);
    set_id(1, 0, 0, 0, 0, 1, 5, 1); cyc();
    set_id(1, 0, 0, 0, 0, 1, 5, 1); cyc();
    set_id(1, 5, 1, 0, 0, 0, 0, 1);
    chk("young fwda", 32'(fwda0), 1);
    cyc();
    idle(4);
    set_id(1, 0, 0, 0, 0, 1, 0, 1); cyc();
    set_id(1, 0, 1, 0, 0, 0, 0, 1);
    chk("r0 fwda", 32'(fwda0), 0);
    chk("r0 stall", 32'(stall0), 0);
    cyc();

    // Flush beats a load-use hazard and inserts a bubble
    idle(4);
    set_id(1, 0, 0, 0, 0, 1, 4, 2); cyc();
    set_id(1, 0, 0, 4, 1, 1, 9, 1);
    flush = 1'b1; #1;
    saved = mcnt[0];
    chk("flush stall", 32'(stall0), 0);
    cyc();
    flush = 1'b0;
    chk("flush cnt", 32'(cnt0), saved);
    set_id(1, 9, 1, 4, 1, 0, 0, 1);
    chk("flush bubble fwda", 32'(fwda0), 0);
    chk("flush fwdb", 32'(fwdb0), 2);
    chk("flush no stall", 32'(stall0), 0);
    cyc();

    // Hold freezes a load-use case
    idle(4);
    set_id(1, 0, 0, 0, 0, 1, 4, 2); cyc();
    set_id(1, 0, 0, 4, 1, 0, 0, 1);
    hold = 1'b1; #1;
    saved = mcnt[0];
    repeat (3) begin
      chk("hold stall", 32'(stall0), 1);
      cyc();
      chk("hold cnt", 32'(cnt0), saved);
    end
    hold = 1'b0; #1;
    chk("unhold stall", 32'(stall0), 1);
    cyc();
    chk("unhold fwdb", 32'(fwdb0), 2);
    chk("unhold stall2", 32'(stall0), 0);
    chk("unhold cnt", 32'(cnt0), saved + 1);
    cyc();

    // Reset discards live entries
    idle(4);
    set_id(1, 0, 0, 0, 0, 1, 6, 3); cyc();
    set_id(1, 0, 0, 0, 0, 1, 7, 3); cyc();
    set_id(1, 0, 0, 0, 0, 1, 8, 3); cyc();
    set_id(1, 8, 1, 6, 1, 0, 0, 1);
    chk("pre-rst stall", 32'(stall0), 1);
    do_reset();
    chk("post-rst stall", 32'(stall0), 0);
    chk("post-rst fwdb", 32'(fwdb0), 0);
    cyc();

    // Stall-only instance: two stall cycles then register-file read
    idle(4);
    set_id(1, 0, 0, 0, 0, 1, 3, 1); cyc();
    set_id(1, 3, 1, 0, 0, 0, 0, 1);
    chk("nofwd stall c1", 32'(stall1), 1);
    cyc();
    chk("nofwd stall c2", 32'(stall1), 1);
    cyc();
    chk("nofwd stall c3", 32'(stall1), 0);
    chk("nofwd fwda", 32'(fwda1), 0);
    cyc();

    // Randomized traffic on a small register range
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      set_id($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 1) != 0, $urandom_range(0, 9) < 7,
             $urandom_range(0, 7), $urandom_range(0, 3));
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 9) == 0);
      #1;
      cyc();
    end
    flush = 1'b0; hold = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
